// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle data-memory responder for the CPU MEM stage. It
//            accepts one load, store or line-refill burst at a time through
//            a valid/ready handshake. After a fixed latency it returns the
//            read data or a write acknowledgement. While an access is in
//            flight req_ready is low, and the CPU uses that as a stall.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            req_valid/req_wr/req_burst/req_addr/req_wdata - request
//            req_ready         - request can be accepted this cycle
//            rsp_valid/rsp_data/rsp_addr - registered response beat
//            busy              - inverse of req_ready (pipeline stall)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4,
  parameter int BURST_LEN   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic        req_burst,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_addr,
  output logic        busy
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam int          CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int          BEAT_W    = $clog2(BURST_LEN) + 1;
  // Byte-offset bits inside one refill line; cleared to line-align a burst.
  localparam logic [15:0] LINE_MASK = 16'(BURST_LEN * 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [15:0] mem [DEPTH_WORDS];

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;   // beats still to be emitted
  logic [15:0]         addr_q, addr_d;     // byte address of the next beat
  logic                wr_q, wr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [15:0]         rsp_data_q, rsp_data_d;
  logic [15:0]         rsp_addr_q, rsp_addr_d;

  logic                accept;
  logic                is_burst;
  logic [15:0]         req_base;
  logic [BEAT_W-1:0]   req_beats;
  logic                emit;
  logic [15:0]         beat_addr;
  logic                beat_wr;
  logic [BEAT_W-1:0]   beat_left;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;

  // A store that also asserts req_burst is still a single store.
  assign is_burst  = req_burst & ~req_wr;
  assign req_base  = is_burst ? (req_addr & ~LINE_MASK) : (req_addr & 16'hFFFE);
  assign req_beats = is_burst ? BEAT_W'(BURST_LEN) : BEAT_W'(1);

  // Next-state and next-output logic. A response beat is prepared one cycle
  // ahead ("emit") so that rsp_* come straight from flops. The array is read
  // here, so any store accepted earlier is already visible.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beats_d     = beats_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    emit        = 1'b0;
    beat_addr   = addr_q;
    beat_wr     = wr_q;
    beat_left   = beats_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = 16'h0000;
    rsp_addr_d  = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = req_wr;
          addr_d  = req_base;
          beats_d = req_beats;
          if (LATENCY == 1) begin
            // No wait phase: the first beat comes from the live request.
            emit      = 1'b1;
            beat_addr = req_base;
            beat_wr   = req_wr;
            beat_left = req_beats;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          emit = 1'b1;
        end
      end
      S_RESP: begin
        if (beats_q != '0) begin
          emit = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (emit) begin
      state_d     = S_RESP;
      addr_d      = beat_addr + 16'd2;
      beats_d     = beat_left - BEAT_W'(1);
      rsp_valid_d = 1'b1;
      rsp_addr_d  = beat_addr;
      rsp_data_d  = beat_wr ? 16'h0000 : mem[beat_addr[IDX_W:1]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      beats_q     <= '0;
      addr_q      <= 16'h0000;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_addr_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beats_q     <= beats_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  // The array has no reset. Stores commit at the acceptance edge, so a
  // later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_wr) begin
      mem[req_addr[IDX_W:1]] <= req_wdata;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder. It loads the
//            array through stores, then runs single loads, stores, bursts,
//            address wrap, the busy drop and reset during a burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int LAT   = 4;
  localparam int BL    = 8;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_wr;
  logic        req_burst;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BURST_LEN  (BL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_wr   (req_wr),
    .req_burst(req_burst),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_addr (rsp_addr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%04h expected 0x%04h", tag, $time, obs, exp);
    end
  endtask

  // Moves to just after the next rising edge, which starts a new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one request from the current cycle (cycle 0). It checks every cycle
  // up to the last beat and returns at the start of the cycle where req_ready
  // should be back. The next request, or a final check, covers that cycle.
  // With hold=1 a competing load at hold_addr stays asserted while busy.
  task automatic run_req(input logic wr, input logic burst,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int nbeats,
                         input logic [15:0] exp_addr0, input logic [15:0] exp_data0,
                         input logic [15:0] step,
                         input logic hold, input logic [15:0] hold_addr);
    req_valid = 1'b1;
    req_wr    = wr;
    req_burst = burst;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    check("ready_c0", {15'd0, req_ready}, 16'd1);
    check("busy_c0",  {15'd0, busy},      16'd0);
    check("valid_c0", {15'd0, rsp_valid}, 16'd0);
    tick();
    for (int c = 1; c < LAT + nbeats; c++) begin
      if (hold) begin
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_burst = 1'b0;
        req_addr  = hold_addr;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      check("ready_busy", {15'd0, req_ready}, 16'd0);
      check("busy_busy",  {15'd0, busy},      16'd1);
      if (c < LAT) begin
        check("valid_wait", {15'd0, rsp_valid}, 16'd0);
      end else begin
        check("valid_beat", {15'd0, rsp_valid}, 16'd1);
        check("addr_beat",  rsp_addr, exp_addr0 + 16'(2 * (c - LAT)));
        check("data_beat",  rsp_data, exp_data0 + 16'(step * 16'(c - LAT)));
      end
      tick();
    end
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_burst = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    tick();
    tick();
    @(negedge clk);
    check("rst_ready", {15'd0, req_ready}, 16'd1);
    check("rst_busy",  {15'd0, busy},      16'd0);
    check("rst_valid", {15'd0, rsp_valid}, 16'd0);
    check("rst_data",  rsp_data, 16'h0000);
    check("rst_addr",  rsp_addr, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    // Preload the array through stores; each ack returns data 0.
    run_req(1'b1, 1'b0, 16'h0020, 16'hBEEF, 1, 16'h0020, 16'h0000, 16'h0000, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++)
      run_req(1'b1, 1'b0, 16'(16'h0030 + 2 * i), 16'(16'h00A0 + i), 1,
              16'(16'h0030 + 2 * i), 16'h0000, 16'h0000, 1'b0, 16'h0);
    run_req(1'b1, 1'b0, 16'h0000, 16'h5A5A, 1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++)
      run_req(1'b1, 1'b0, 16'(16'h07F0 + 2 * i), 16'(16'h00C0 + i), 1,
              16'(16'h07F0 + 2 * i), 16'h0000, 16'h0000, 1'b0, 16'h0);

    // Single load of mem[0x10].
    run_req(1'b0, 1'b0, 16'h0020, 16'h0000, 1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0, 16'h0);

    // Store with address bit 0 set, then back-to-back load.
    run_req(1'b1, 1'b0, 16'h0103, 16'h1234, 1, 16'h0102, 16'h0000, 16'h0000, 1'b0, 16'h0);
    run_req(1'b0, 1'b0, 16'h0102, 16'h0000, 1, 16'h0102, 16'h1234, 16'h0000, 1'b0, 16'h0);

    // Burst at 0x0036, line base 0x0030.
    run_req(1'b0, 1'b1, 16'h0036, 16'h0000, BL, 16'h0030, 16'h00A0, 16'h0001, 1'b0, 16'h0);

    // Busy drop: a held request is accepted only when ready returns.
    run_req(1'b0, 1'b0, 16'h0020, 16'h0000, 1, 16'h0020, 16'hBEEF, 16'h0000, 1'b1, 16'h0102);
    run_req(1'b0, 1'b0, 16'h0102, 16'h0000, 1, 16'h0102, 16'h1234, 16'h0000, 1'b0, 16'h0);

    // Wrap-around: 0x0800 aliases word 0, and 0xFFF0 aliases words 0x3F8.
    run_req(1'b0, 1'b0, 16'h0800, 16'h0000, 1, 16'h0800, 16'h5A5A, 16'h0000, 1'b0, 16'h0);
    run_req(1'b0, 1'b1, 16'hFFF0, 16'h0000, BL, 16'hFFF0, 16'h00C0, 16'h0001, 1'b0, 16'h0);

    // A store that also asserts req_burst is a single store.
    run_req(1'b1, 1'b1, 16'h0104, 16'h7777, 1, 16'h0104, 16'h0000, 16'h0000, 1'b0, 16'h0);
    run_req(1'b0, 1'b0, 16'h0104, 16'h0000, 1, 16'h0104, 16'h7777, 16'h0000, 1'b0, 16'h0);

    // Reset in cycle 6 of a burst.
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_burst = 1'b1;
    req_addr  = 16'h0036;
    @(negedge clk);
    check("mr_ready_c0", {15'd0, req_ready}, 16'd1);
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      check("mr_valid", {15'd0, rsp_valid}, (c >= LAT) ? 16'd1 : 16'd0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mr_rst_valid", {15'd0, rsp_valid}, 16'd0);
    check("mr_rst_ready", {15'd0, req_ready}, 16'd1);
    check("mr_rst_busy",  {15'd0, busy},      16'd0);
    check("mr_rst_data",  rsp_data, 16'h0000);
    check("mr_rst_addr",  rsp_addr, 16'h0000);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("mr_no_residual", {15'd0, rsp_valid}, 16'd0);
      check("mr_idle_ready",  {15'd0, req_ready}, 16'd1);
      tick();
    end
    run_req(1'b0, 1'b0, 16'h0020, 16'h0000, 1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0, 16'h0);
    run_req(1'b0, 1'b0, 16'h0102, 16'h0000, 1, 16'h0102, 16'h1234, 16'h0000, 1'b0, 16'h0);

    @(negedge clk);
    check("end_ready", {15'd0, req_ready}, 16'd1);
    check("end_valid", {15'd0, rsp_valid}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
